// File: rtl/cg_pkg.sv
// Shared defaults and types for the conjugate-gradient vector datapath.
package cg_pkg;
  localparam int DEF_ELEMENT_WIDTH = 32;
  localparam int DEF_NO_OF_UNITS   = 8;
  localparam int ROW_WIDTH         = DEF_ELEMENT_WIDTH * DEF_NO_OF_UNITS;
  localparam int NUM_BANKS         = 3;

  typedef logic [ROW_WIDTH-1:0] row_t;
  typedef logic [1:0]           bank_sel_t;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } wr_state_e;
endpackage

// File: rtl/cg_row_ram.sv
// One vector bank: DEPTH rows, a synchronous write port and two registered read ports.
module cg_row_ram
  import cg_pkg::*;
#(
  parameter int DATA_WIDTH = ROW_WIDTH,
  parameter int DEPTH      = 1000,
  parameter int ADDR_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  input  logic                  re_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  output logic [DATA_WIDTH-1:0] rdata_b_o
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic we_ok, re_a_ok, re_b_ok;

  // Addresses beyond the physical depth are dropped rather than aliased.
  assign we_ok   = we_i   && (32'(waddr_i)   < 32'(DEPTH));
  assign re_a_ok = re_a_i && (32'(raddr_a_i) < 32'(DEPTH));
  assign re_b_ok = re_b_i && (32'(raddr_b_i) < 32'(DEPTH));

  always_ff @(posedge clk) begin
    if (we_ok)   mem_q[waddr_i[IDX_W-1:0]] <= wdata_i;
    if (re_a_ok) rdata_a_o <= mem_q[raddr_a_i[IDX_W-1:0]];
    if (re_b_ok) rdata_b_o <= mem_q[raddr_b_i[IDX_W-1:0]];
  end
endmodule

// File: rtl/cg_vector_bank.sv
// Triple-banked row store: one bank fills while the current and previous vectors stay readable.
module cg_vector_bank
  import cg_pkg::*;
#(
  parameter int ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
  parameter int NO_OF_UNITS   = DEF_NO_OF_UNITS,
  parameter int MEMORY_HEIGHT = 1000,
  parameter int ADDR_WIDTH    = $clog2(MEMORY_HEIGHT) + 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [31:0]                          total,
  input  logic                                 wr_en,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] wr_data,
  output logic                                 wr_done,
  input  logic                                 rd_cur_en,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] rd_cur_data,
  output logic                                 rd_cur_valid,
  input  logic                                 rd_prev_en,
  input  logic [ADDR_WIDTH-1:0]                rd_prev_addr,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] rd_prev_data,
  output logic                                 rd_prev_valid,
  input  logic                                 swap,
  output logic                                 full,
  output logic                                 err
);
  localparam int ROW_W = ELEMENT_WIDTH * NO_OF_UNITS;

  wr_state_e             state_q, state_d;
  logic [31:0]           rows_q, rows_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_cur_ptr_q, rd_cur_ptr_d;
  bank_sel_t             wr_sel_q, wr_sel_d, cur_sel_q, cur_sel_d, prev_sel_q, prev_sel_d;
  bank_sel_t             cur_rsel_q, prev_rsel_q;
  logic                  wr_done_q, wr_done_d, err_q, err_d;
  logic                  cur_valid_q, prev_valid_q, cur_zero_q, prev_zero_q;
  logic                  wr_fire, wr_last, cur_last, prev_oor, prev_fire, swap_ok;
  logic [ROW_W-1:0]      bank_cur_data [NUM_BANKS];
  logic [ROW_W-1:0]      bank_prev_data [NUM_BANKS];

  always_comb begin
    wr_last   = (32'(wr_ptr_q) == rows_q - 32'd1);
    cur_last  = (32'(rd_cur_ptr_q) + 32'd1 >= rows_q);
    prev_oor  = (32'(rd_prev_addr) >= rows_q);
    prev_fire = rd_prev_en && !prev_oor;
    swap_ok   = swap && (state_q == ST_FULL);
    wr_fire   = wr_en && (state_q != ST_FULL) && (rows_q != 32'd0);
  end

  always_comb begin
    state_d      = state_q;
    rows_d       = rows_q;
    wr_ptr_d     = wr_ptr_q;
    rd_cur_ptr_d = rd_cur_ptr_q;
    wr_sel_d     = wr_sel_q;
    cur_sel_d    = cur_sel_q;
    prev_sel_d   = prev_sel_q;
    wr_done_d    = 1'b0;
    err_d        = err_q;

    // A zero-length vector is complete before anything is written.
    if (state_q == ST_EMPTY && rows_q == 32'd0) state_d = ST_FULL;

    if (wr_fire) begin
      if (wr_last) begin
        state_d   = ST_FULL;
        wr_done_d = 1'b1;
      end else begin
        state_d  = ST_FILLING;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    if (rd_cur_en) rd_cur_ptr_d = cur_last ? '0 : rd_cur_ptr_q + 1'b1;

    // Reads in the swap cycle already used the old selects; only the state moves here.
    if (swap_ok) begin
      prev_sel_d   = cur_sel_q;
      cur_sel_d    = wr_sel_q;
      wr_sel_d     = prev_sel_q;
      wr_ptr_d     = '0;
      rd_cur_ptr_d = '0;
      rows_d       = total / 32'(NO_OF_UNITS);
      state_d      = ST_EMPTY;
    end

    if ((wr_en && !wr_fire) || (swap && !swap_ok) || (rd_prev_en && prev_oor)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      rows_q       <= total / 32'(NO_OF_UNITS);
      wr_ptr_q     <= '0;
      rd_cur_ptr_q <= '0;
      wr_sel_q     <= 2'd0;
      cur_sel_q    <= 2'd1;
      prev_sel_q   <= 2'd2;
      cur_rsel_q   <= 2'd0;
      prev_rsel_q  <= 2'd0;
      wr_done_q    <= 1'b0;
      err_q        <= 1'b0;
      cur_valid_q  <= 1'b0;
      prev_valid_q <= 1'b0;
      cur_zero_q   <= 1'b1;
      prev_zero_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      rows_q       <= rows_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_cur_ptr_q <= rd_cur_ptr_d;
      wr_sel_q     <= wr_sel_d;
      cur_sel_q    <= cur_sel_d;
      prev_sel_q   <= prev_sel_d;
      wr_done_q    <= wr_done_d;
      err_q        <= err_d;
      cur_valid_q  <= rd_cur_en;
      prev_valid_q <= rd_prev_en;
      if (rd_cur_en) begin
        cur_rsel_q <= cur_sel_q;
        cur_zero_q <= 1'b0;
      end
      if (rd_prev_en) begin
        prev_rsel_q <= prev_sel_q;
        prev_zero_q <= prev_oor;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    cg_row_ram #(
      .DATA_WIDTH (ROW_W),
      .DEPTH      (MEMORY_HEIGHT),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
      .clk       (clk),
      .we_i      (wr_fire && (wr_sel_q == bank_sel_t'(gi))),
      .waddr_i   (wr_ptr_q),
      .wdata_i   (wr_data),
      .re_a_i    (rd_cur_en && (cur_sel_q == bank_sel_t'(gi))),
      .raddr_a_i (rd_cur_ptr_q),
      .rdata_a_o (bank_cur_data[gi]),
      .re_b_i    (prev_fire && (prev_sel_q == bank_sel_t'(gi))),
      .raddr_b_i (rd_prev_addr),
      .rdata_b_o (bank_prev_data[gi])
    );
  end

  // Bank read registers are not reset, so the zero flags mask them until a real read lands.
  always_comb begin
    rd_cur_data  = '0;
    rd_prev_data = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (!cur_zero_q && cur_rsel_q == bank_sel_t'(i))   rd_cur_data  = bank_cur_data[i];
      if (!prev_zero_q && prev_rsel_q == bank_sel_t'(i)) rd_prev_data = bank_prev_data[i];
    end
  end

  assign wr_done       = wr_done_q;
  assign full          = (state_q == ST_FULL);
  assign err           = err_q;
  assign rd_cur_valid  = cur_valid_q;
  assign rd_prev_valid = prev_valid_q;
endmodule

// File: tb/tb_cg_vector_bank.sv
// Self-checking bench for cg_vector_bank: table-driven reads plus scoreboarded read ports.
module tb_cg_vector_bank;
  import cg_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] total;
  logic        wr_en;
  row_t        wr_data;
  logic        wr_done;
  logic        rd_cur_en;
  row_t        rd_cur_data;
  logic        rd_cur_valid;
  logic        rd_prev_en;
  logic [10:0] rd_prev_addr;
  row_t        rd_prev_data;
  logic        rd_prev_valid;
  logic        swap;
  logic        full;
  logic        err;

  int passes = 0;
  int checks = 0;

  row_t cur_exp_q[$];
  row_t prev_exp_q[$];
  logic cur_req_q  = 1'b0;
  logic prev_req_q = 1'b0;

  typedef struct {
    logic        prev_en;
    logic [10:0] addr;
    logic        cur_en;
    row_t        exp_prev;
    row_t        exp_cur;
    logic        exp_err;
  } rd_vec_t;

  rd_vec_t tbl [5];

  cg_vector_bank dut (
    .clk           (clk),
    .reset         (reset),
    .total         (total),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .wr_done       (wr_done),
    .rd_cur_en     (rd_cur_en),
    .rd_cur_data   (rd_cur_data),
    .rd_cur_valid  (rd_cur_valid),
    .rd_prev_en    (rd_prev_en),
    .rd_prev_addr  (rd_prev_addr),
    .rd_prev_data  (rd_prev_data),
    .rd_prev_valid (rd_prev_valid),
    .swap          (swap),
    .full          (full),
    .err           (err)
  );

  always #5 clk = ~clk;

  function automatic row_t mkrow(input int tag, input int idx);
    row_t r;
    for (int e = 0; e < DEF_NO_OF_UNITS; e++)
      r[e*32 +: 32] = 32'(tag << 24) | 32'(idx << 16) | 32'(e << 8) | 32'h5A;
    return r;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic check_row(input string name, input row_t act, input row_t exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cur(input int tag, input int idx);
    rd_cur_en = 1'b1;
    cur_exp_q.push_back(mkrow(tag, idx));
  endtask

  task automatic push_prev(input logic [10:0] addr, input row_t exp);
    rd_prev_en   = 1'b1;
    rd_prev_addr = addr;
    prev_exp_q.push_back(exp);
  endtask

  task automatic idle_reads();
    rd_cur_en  = 1'b0;
    rd_prev_en = 1'b0;
  endtask

  // Writes rows first..first+n-1 back to back; wr_done is expected only after row done_at.
  task automatic fill(input int tag, input int first, input int n, input int done_at);
    for (int i = first; i < first + n; i++) begin
      wr_en   = 1'b1;
      wr_data = mkrow(tag, i);
      tick();
      check_bit($sformatf("wr_done_t%0d_r%0d", tag, i), wr_done, i == done_at);
    end
    wr_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_bit({tag, "_wr_done"}, wr_done, 1'b0);
    check_bit({tag, "_full"}, full, 1'b0);
    check_bit({tag, "_err"}, err, 1'b0);
    check_bit({tag, "_cur_valid"}, rd_cur_valid, 1'b0);
    check_bit({tag, "_prev_valid"}, rd_prev_valid, 1'b0);
    check_row({tag, "_cur_data"}, rd_cur_data, '0);
    check_row({tag, "_prev_data"}, rd_prev_data, '0);
  endtask

  always @(posedge clk) begin
    cur_req_q  <= rd_cur_en && !reset;
    prev_req_q <= rd_prev_en && !reset;
  end

  // Read ports: valid must follow the request by one cycle and carry the queued row.
  always @(negedge clk) begin
    if (cur_req_q || rd_cur_valid) begin
      check_bit("cur_valid", rd_cur_valid, cur_req_q);
      if (cur_req_q) begin
        if (cur_exp_q.size() == 0) begin
          checks++;
          $display("FAIL cur_scoreboard: got a read with no expected row");
        end else check_row("cur_data", rd_cur_data, cur_exp_q.pop_front());
      end
    end
    if (prev_req_q || rd_prev_valid) begin
      check_bit("prev_valid", rd_prev_valid, prev_req_q);
      if (prev_req_q) begin
        if (prev_exp_q.size() == 0) begin
          checks++;
          $display("FAIL prev_scoreboard: got a read with no expected row");
        end else check_row("prev_data", rd_prev_data, prev_exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 11'd2, 1'b1, mkrow(8'hA, 2), mkrow(8'hB, 0), 1'b0};
    tbl[1] = '{1'b1, 11'd0, 1'b1, mkrow(8'hA, 0), mkrow(8'hB, 1), 1'b0};
    tbl[2] = '{1'b1, 11'd3, 1'b0, mkrow(8'hA, 3), '0,             1'b0};
    tbl[3] = '{1'b0, 11'd0, 1'b1, '0,             mkrow(8'hB, 2), 1'b0};
    tbl[4] = '{1'b1, 11'd1, 1'b1, mkrow(8'hA, 1), mkrow(8'hB, 3), 1'b0};

    reset = 1'b1; total = 32'd32; wr_en = 1'b0; wr_data = '0;
    rd_cur_en = 1'b0; rd_prev_en = 1'b0; rd_prev_addr = '0; swap = 1'b0;
    tick(); tick();
    check_reset_outputs("rst0");
    reset = 1'b0;

    // Vector A, then rotate it to current and read past the end to see the wrap.
    fill(8'hA, 0, 4, 3);
    check_bit("full_after_A", full, 1'b1);
    check_bit("err_after_A", err, 1'b0);
    tick();
    check_bit("wr_done_single_pulse", wr_done, 1'b0);
    swap = 1'b1; tick(); swap = 1'b0;
    check_bit("full_after_swap", full, 1'b0);
    for (int i = 0; i < 5; i++) begin
      push_cur(8'hA, i % 4);
      tick();
    end
    idle_reads();

    fill(8'hB, 0, 4, 3);
    swap = 1'b1; tick(); swap = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_prev_en   = 1'b0;
      rd_cur_en    = 1'b0;
      if (tbl[i].prev_en) push_prev(tbl[i].addr, tbl[i].exp_prev);
      if (tbl[i].cur_en)  begin rd_cur_en = 1'b1; cur_exp_q.push_back(tbl[i].exp_cur); end
      tick();
      check_bit($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
    end
    idle_reads();

    // Reads in the swap cycle see the old banks; the next reads see the rotated ones.
    fill(8'hC, 0, 4, 3);
    swap = 1'b1;
    push_cur(8'hB, 0);
    push_prev(11'd1, mkrow(8'hA, 1));
    tick();
    swap = 1'b0;
    push_cur(8'hC, 0);
    push_prev(11'd1, mkrow(8'hB, 1));
    tick();
    idle_reads();
    check_bit("err_inrange_reads", err, 1'b0);
    push_prev(11'd4, '0);
    tick();
    idle_reads();
    check_bit("err_prev_oor", err, 1'b1);
    tick();

    // Rejected swap while filling must leave selects and the fill position intact.
    reset = 1'b1; tick(); tick();
    check_reset_outputs("rst1");
    reset = 1'b0;
    fill(8'hD, 0, 2, -1);
    swap = 1'b1; tick(); swap = 1'b0;
    check_bit("err_swap_filling", err, 1'b1);
    check_bit("full_swap_filling", full, 1'b0);
    fill(8'hD, 2, 2, 3);
    swap = 1'b1; tick(); swap = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_cur(8'hD, i);
      tick();
    end
    idle_reads();

    // Reset mid-fill aborts it; the next four writes form a complete vector.
    reset = 1'b1; tick(); reset = 1'b0;
    fill(8'h6, 0, 2, -1);
    reset = 1'b1; tick(); tick();
    check_reset_outputs("rst2");
    reset = 1'b0;
    fill(8'hE, 0, 4, 3);
    check_bit("err_after_E", err, 1'b0);
    wr_en = 1'b1; wr_data = mkrow(8'hF, 0); tick(); wr_en = 1'b0;
    check_bit("err_wr_full", err, 1'b1);
    check_bit("wr_done_wr_full", wr_done, 1'b0);
    check_bit("full_wr_full", full, 1'b1);
    swap = 1'b1; wr_en = 1'b1; wr_data = mkrow(8'hF, 1); tick();
    swap = 1'b0; wr_en = 1'b0;
    check_bit("full_swap_with_wr", full, 1'b0);
    for (int i = 0; i < 4; i++) begin
      push_cur(8'hE, i);
      tick();
    end
    idle_reads();
    fill(8'h8, 0, 4, 3);

    // total=8 gives single-row vectors: wrap on every read, addr 1 is out of range.
    total = 32'd8;
    swap = 1'b1; tick(); swap = 1'b0;
    total = 32'd32;
    push_cur(8'h8, 0);
    push_prev(11'd0, mkrow(8'hE, 0));
    tick();
    push_cur(8'h8, 0);
    push_prev(11'd1, '0);
    tick();
    idle_reads();
    fill(8'h9, 0, 1, 0);
    check_bit("full_rows1", full, 1'b1);

    tick(); tick(); tick();
    checks++;
    if (cur_exp_q.size() == 0 && prev_exp_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d/%0d rows left expected 0/0",
                  cur_exp_q.size(), prev_exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
